// File: rtl/ov7670_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ov7670_pkg : shared encodings and defaults for the OV7670 FIFO path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VS1 = 3'd1,
    ST_WRITE    = 3'd2,
    ST_WAIT_VS2 = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_RD_WAIT  = 3'd5
  } state_e;

  localparam int unsigned WRST_CYCLES_DEFAULT    = 4;
  localparam logic [31:0] TIMEOUT_CYCLES_DEFAULT = 32'd4000000;

  // VGA RGB565 frame as stored in the camera FIFO
  localparam int unsigned FRAME_BYTES = 640 * 480 * 2;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WAIT_VS1) || (s == ST_WAIT_VS2) ||
           (s == ST_RD_REQ)   || (s == ST_RD_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ov7670_edge_sync : 2-FF synchronizer plus registered rise detector   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ov7670_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_prev;
  logic       r_rise;
  logic [1:0] r_fill;

  // r_fill blocks a rise until r_s2 and r_prev both hold real samples, so a
  // level already high at reset release is not mistaken for a fresh edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
      r_rise <= (r_fill == 2'd3) && r_s2 && !r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/ov7670_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ov7670_frame_arbiter : sequences camera FIFO write and reader start  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ov7670_frame_arbiter
  import ov7670_pkg::*;
#(
  parameter int unsigned WRST_CYCLES    = WRST_CYCLES_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        i_clk_40m,
  input  logic        i_rst_n,
  input  logic        i_ov_vsync,
  input  logic        i_frame_req,
  input  logic        i_cont_mode,
  input  logic        i_rd_frame,
  output logic        o_ov_wrst,
  output logic        o_ov_wen,
  output logic        o_read_en,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic        o_err
);

  localparam logic [7:0]  c_wrst_last = 8'(WRST_CYCLES - 1);
  localparam logic [31:0] c_tmo_last  = TIMEOUT_CYCLES - 32'd1;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_vs_rise;
  logic        r_pend;
  logic        r_rd_prev;
  logic [7:0]  r_wrst_cnt;
  logic [31:0] r_tmo;
  logic        r_wrst;
  logic        r_wen;
  logic        r_read_en;
  logic        r_busy;
  logic        r_err;
  logic [15:0] r_frame_cnt;
  logic        w_wrst_nxt;
  logic        w_wen_nxt;
  logic        w_read_en_nxt;
  logic        w_frame_done;
  logic        w_tmo_hit;
  logic        w_tmo_fire;

  ov7670_edge_sync u_vs_sync (
    .i_clk   (i_clk_40m),
    .i_rst_n (i_rst_n),
    .i_async (i_ov_vsync),
    .o_rise  (w_vs_rise)
  );

  assign w_tmo_hit = (r_tmo == c_tmo_last);

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    w_state_nxt   = r_state;
    w_wrst_nxt    = 1'b1;
    w_wen_nxt     = 1'b0;
    w_read_en_nxt = 1'b0;
    w_frame_done  = 1'b0;
    w_tmo_fire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_req || r_pend || i_cont_mode) begin
          w_state_nxt = ST_WAIT_VS1;
        end
      end
      ST_WAIT_VS1: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_WRITE;
          w_wrst_nxt  = 1'b0;
          w_wen_nxt   = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_tmo_fire  = 1'b1;
        end
      end
      ST_WRITE: begin
        w_wen_nxt = 1'b1;
        if (r_wrst_cnt == c_wrst_last) begin
          w_state_nxt = ST_WAIT_VS2;
        end else begin
          w_wrst_nxt = 1'b0;
        end
      end
      ST_WAIT_VS2: begin
        if (w_vs_rise) begin
          w_state_nxt   = ST_RD_REQ;
          w_read_en_nxt = 1'b1;
          w_frame_done  = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_tmo_fire  = 1'b1;
        end else begin
          w_wen_nxt = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (!i_rd_frame) begin
          w_state_nxt = ST_RD_WAIT;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_tmo_fire  = 1'b1;
        end else begin
          w_read_en_nxt = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        // Only a fresh 0->1 edge ends the wait, not a level that was already high.
        if (i_rd_frame && !r_rd_prev) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_tmo_fire  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_40m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pend      <= 1'b0;
      r_rd_prev   <= 1'b0;
      r_wrst_cnt  <= 8'd0;
      r_tmo       <= 32'd0;
      r_wrst      <= 1'b1;
      r_wen       <= 1'b0;
      r_read_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_wrst    <= w_wrst_nxt;
      r_wen     <= w_wen_nxt;
      r_read_en <= w_read_en_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_rd_prev <= i_rd_frame;

      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_tmo_fire) begin
        r_err <= 1'b1;
      end

      // Requests outside IDLE (including the cycle IDLE is entered) are held once.
      if (r_state == ST_IDLE) begin
        if (w_state_nxt == ST_WAIT_VS1) begin
          r_pend <= 1'b0;
        end
      end else if (i_frame_req) begin
        r_pend <= 1'b1;
      end

      if (w_state_nxt != r_state) begin
        r_tmo      <= 32'd0;
        r_wrst_cnt <= 8'd0;
      end else begin
        if (is_wait_state(r_state)) begin
          r_tmo <= r_tmo + 32'd1;
        end
        if (r_state == ST_WRITE) begin
          r_wrst_cnt <= r_wrst_cnt + 8'd1;
        end
      end
    end
  end

  assign o_ov_wrst   = r_wrst;
  assign o_ov_wen    = r_wen;
  assign o_read_en   = r_read_en;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ov7670_frame_arbiter : self-checking bench for the frame arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ov7670_frame_arbiter;

  localparam int WRST = 4;
  localparam int TMO  = 1000;

  typedef struct {
    int req;
    int gap;
    int per;
    int vlen;
    int glitch;
    int req_a;
    int req_b;
    int dd;
    int dr;
    int exp_wen_len;
    int exp_re_len;
  } vec_t;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        vsync     = 1'b0;
  logic        frame_req = 1'b0;
  logic        cont_mode = 1'b0;
  logic        rd_frame  = 1'b1;
  logic        wrst;
  logic        wen;
  logic        read_en;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err;

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          viol   = 0;
  logic [15:0] cnt_model = 16'd0;

  ov7670_frame_arbiter #(
    .WRST_CYCLES    (WRST),
    .TIMEOUT_CYCLES (32'(TMO))
  ) dut (
    .i_clk_40m   (clk),
    .i_rst_n     (rst_n),
    .i_ov_vsync  (vsync),
    .i_frame_req (frame_req),
    .i_cont_mode (cont_mode),
    .i_rd_frame  (rd_frame),
    .o_ov_wrst   (wrst),
    .o_ov_wen    (wen),
    .o_read_en   (read_en),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt),
    .o_err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output relationships that must hold in every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_en && wen) viol++;
      if (!wrst && !wen) viol++;
      if (!busy && (wen || read_en || !wrst)) viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_check(input string name, input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) hi++;
    end
    chk(name, hi, 0);
  endtask

  function automatic vec_t rand_vec(input int req);
    vec_t v;
    v.req         = req;
    v.gap         = int'($urandom_range(20, 1));
    v.per         = int'($urandom_range(120, 30));
    v.vlen        = int'($urandom_range(4, 1));
    v.glitch      = 0;
    v.req_a       = -1;
    v.req_b       = -1;
    v.dd          = int'($urandom_range(5, 1));
    v.dr          = int'($urandom_range(60, 10));
    v.exp_wen_len = v.per;
    v.exp_re_len  = v.dd + 1;
    return v;
  endfunction

  // One captured frame: vsync rises at t0 and t0+per, the reader answers
  // READ_EN after dd clocks and finishes dr clocks later.
  task automatic run_frame(input string tag, input vec_t v);
    int  t0, t_drop, t_raise, lim;
    int  wrst_first, wrst_n, wen_first, wen_n, re_first, re_n, busy_low;
    bit  done;
    t0 = cyc + v.gap;
    t_drop = -1; t_raise = -1;
    wrst_first = -1; wrst_n = 0; wen_first = -1; wen_n = 0;
    re_first = -1; re_n = 0; busy_low = -1; done = 0;
    lim = v.gap + v.per + v.dd + v.dr + 200;
    if (v.req != 0) frame_req = 1'b1;
    for (int i = 0; i < lim && !done; i++) begin
      @(negedge clk);
      if (wrst === 1'b0) begin
        if (wrst_first < 0) wrst_first = cyc;
        wrst_n++;
      end
      if (wen === 1'b1) begin
        if (wen_first < 0) wen_first = cyc;
        wen_n++;
      end
      if (read_en === 1'b1) begin
        if (re_first < 0) re_first = cyc;
        re_n++;
      end
      if (re_first >= 0 && t_drop < 0) begin
        t_drop  = re_first + v.dd;
        t_raise = t_drop + v.dr;
      end
      if (t_raise >= 0 && cyc > t_raise && busy === 1'b0) begin
        busy_low = cyc;
        done = 1;
      end
      frame_req = ((v.req_a >= 0) && (cyc == t0 + v.req_a)) ||
                  ((v.req_b >= 0) && (cyc == t0 + v.req_b));
      vsync     = ((cyc >= t0) && (cyc < t0 + v.vlen)) ||
                  ((v.glitch != 0) && (cyc == t0 + v.vlen + 1)) ||
                  ((cyc >= t0 + v.per) && (cyc < t0 + v.per + 4));
      rd_frame  = !((t_drop >= 0) && (cyc >= t_drop) && (cyc < t_raise));
    end
    frame_req = 1'b0;
    cnt_model = cnt_model + 16'd1;
    chk({tag, " wrst_start"}, wrst_first, t0 + 4);
    chk({tag, " wrst_len"},   wrst_n,     WRST);
    chk({tag, " wen_start"},  wen_first,  t0 + 4);
    chk({tag, " wen_len"},    wen_n,      v.exp_wen_len);
    chk({tag, " rden_start"}, re_first,   t0 + v.per + 4);
    chk({tag, " rden_len"},   re_n,       v.exp_re_len);
    chk({tag, " busy_drop"},  busy_low,   t_raise + 1);
    chk({tag, " frame_cnt"},  frame_cnt,  cnt_model);
  endtask

  vec_t tbl[5];
  vec_t rv;
  int   c1, err_at, hi, t0;

  initial begin
    //        req gap per vlen gl  ra  rb  dd  dr  wen re
    tbl[0] = '{1, 5, 500, 4, 0, -1, -1, 2, 300, 500, 3};
    tbl[1] = '{1, 3,  40, 4, 0, 15, 25, 1,  20,  40, 2};
    tbl[2] = '{0, 2,  60, 4, 0, -1, -1, 4,  12,  60, 5};
    tbl[3] = '{1, 4,  50, 1, 1, -1, -1, 2,  15,  50, 3};
    tbl[4] = '{1, 2,  30, 4, 0, -1, -1, 1,  10,  30, 2};

    repeat (3) @(negedge clk);
    chk("rst_wrst",  wrst,      1);
    chk("rst_wen",   wen,       0);
    chk("rst_rden",  read_en,   0);
    chk("rst_busy",  busy,      0);
    chk("rst_cnt",   frame_cnt, 0);
    chk("rst_err",   err,       0);
    rst_n = 1'b1;
    idle_check("idle_no_req", 10);

    // Row 1 requests twice during WAIT_VS2; row 2 is the single pending frame.
    for (int k = 0; k < 5; k++) begin
      run_frame($sformatf("tbl%0d", k), tbl[k]);
      if (k == 2) idle_check("pend_single", 30);
    end
    idle_check("idle_after_tbl", 10);

    for (int k = 0; k < 4; k++) begin
      rv = rand_vec(1);
      run_frame($sformatf("rnd%0d", k), rv);
    end

    cont_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rv = rand_vec(0);
      run_frame($sformatf("cont%0d", k), rv);
    end
    cont_mode = 1'b0;
    idle_check("idle_after_cont", 20);

    // No vsync: the wait must time out after TMO clocks in WAIT_VS1.
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    c1 = cyc;
    chk("tmo_busy_start", busy, 1);
    err_at = -1;
    for (int i = 0; i < TMO + 100 && err_at < 0; i++) begin
      @(negedge clk);
      if (err === 1'b1) err_at = cyc;
    end
    chk("tmo_err_cycle", err_at, c1 + TMO);
    chk("tmo_busy",      busy,    0);
    chk("tmo_wen",       wen,     0);
    chk("tmo_wrst",      wrst,    1);
    chk("tmo_rden",      read_en, 0);
    repeat (20) @(negedge clk);
    chk("err_sticky", err, 1);

    // Reset in the middle of WRITE, with vsync left high across the reset.
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    vsync = 1'b1;
    t0 = cyc;
    repeat (5) @(negedge clk);
    chk("mid_write_wen",  wen,  1);
    chk("mid_write_wrst", wrst, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wrst", wrst,      1);
    chk("arst_wen",  wen,       0);
    chk("arst_rden", read_en,   0);
    chk("arst_busy", busy,      0);
    chk("arst_cnt",  frame_cnt, 0);
    chk("arst_err",  err,       0);
    @(negedge clk);
    rst_n = 1'b1;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (wen !== 1'b0) hi++;
    end
    chk("no_stale_vsync", hi, 0);
    chk("post_rst_waiting", busy, 1);
    cnt_model = 16'd0;
    run_frame("post_rst", '{0, 5, 40, 4, 0, -1, -1, 2, 20, 40, 3});

    chk("invariants", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
